// File: rtl/mp_mem_ctrl.sv
// Multi-precision weight store: binary/ternary/full words with per-address precision tags,
// valid/ready request port, back-pressurable read response and a self-clearing sweep.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | sweeping every address to zero / INVALID tag, no requests
// ST_IDLE  | accepting read and write requests
module mp_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              clear_busy,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_mode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              wr_err
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic [1:0]        low_q  [DEPTH];
    logic [DATA_W-1:0] full_q [DEPTH];
    logic [1:0]        tag_q  [DEPTH];
    logic              resp_valid_q;
    logic              resp_err_q;
    logic              wr_err_q;
    logic [DATA_W-1:0] resp_rdata_q;

    logic              accept;
    logic              rd_accept;
    logic              wr_accept;
    logic              rd_err;
    logic              wr_bad;
    logic [1:0]        cur_tag;
    logic [1:0]        cur_low;
    logic [DATA_W-1:0] cur_full;
    logic [1:0]        tern_low_d;
    logic [DATA_W-1:0] rdata_d;

    assign clear_busy = (state_q == ST_CLEAR);
    assign req_ready  = (state_q == ST_IDLE) && !clear_req && (!resp_valid_q || resp_ready);
    assign accept     = req_valid && req_ready;
    assign rd_accept  = accept && !req_we;
    assign wr_accept  = accept && req_we;

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign wr_err     = wr_err_q;

    assign cur_tag  = tag_q[req_addr];
    assign cur_low  = low_q[req_addr];
    assign cur_full = full_q[req_addr];

    // Ternary has no encoding for 2'b10; it is stored as zero and flagged.
    assign tern_low_d = (req_wdata[1:0] == 2'b10) ? 2'b00 : req_wdata[1:0];
    assign wr_bad     = (req_mode == 2'b11) ||
                        ((req_mode == 2'b01) && (req_wdata[1:0] == 2'b10));
    assign rd_err     = (req_mode == 2'b11) || (cur_tag != req_mode);

    always_comb begin
        rdata_d = '0;
        case (req_mode)
            2'b00: rdata_d = {{(DATA_W-1){1'b0}}, cur_low[0]};
            2'b01: begin
                if (cur_low == 2'b01)
                    rdata_d = {{(DATA_W-1){1'b0}}, 1'b1};
                else if (cur_low == 2'b11)
                    rdata_d = '1;
            end
            2'b10: rdata_d = cur_full;
            default: rdata_d = '0;
        endcase
        if (rd_err)
            rdata_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            wr_err_q <= wr_accept && wr_bad;

            if (resp_valid_q && resp_ready)
                resp_valid_q <= 1'b0;
            if (rd_accept) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= rdata_d;
                resp_err_q   <= rd_err;
            end

            case (state_q)
                ST_CLEAR: begin
                    low_q[clr_addr_q]  <= 2'b00;
                    full_q[clr_addr_q] <= '0;
                    tag_q[clr_addr_q]  <= 2'b11;
                    clr_addr_q         <= clr_addr_q + ADDR_W'(1);
                    if (&clr_addr_q)
                        state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        state_q    <= ST_CLEAR;
                        clr_addr_q <= '0;
                    end
                    if (wr_accept) begin
                        case (req_mode)
                            2'b00: begin
                                low_q[req_addr] <= {1'b0, req_wdata[0]};
                                tag_q[req_addr] <= 2'b00;
                            end
                            2'b01: begin
                                low_q[req_addr] <= tern_low_d;
                                tag_q[req_addr] <= 2'b01;
                            end
                            2'b10: begin
                                full_q[req_addr] <= req_wdata;
                                tag_q[req_addr]  <= 2'b10;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_mp_mem_ctrl.sv
// Self-checking bench for mp_mem_ctrl: directed scenarios plus randomized traffic
// checked against a per-address (precision, value) reference model.
module tb_mp_mem_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear_req = 1'b0;
    logic              clear_busy;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_mode = 2'b00;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              wr_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: precision last written and the value a matching read returns.
    logic [1:0]        m_tag [DEPTH];
    logic [DATA_W-1:0] m_val [DEPTH];

    always #5 clk = ~clk;

    mp_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_mode   (req_mode),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .wr_err     (wr_err)
    );

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_tag[i] = 2'b11;
            m_val[i] = '0;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 2000) begin
            tick();
            n++;
        end
        if (!req_ready)
            check_eq("ready_timeout", {31'b0, req_ready}, 1);
    endtask

    // Counts busy cycles from "now" (just after the edge that entered the clear).
    task automatic count_clear(input string tag);
        int  cnt = 0;
        logic bad = 1'b0;
        while (clear_busy && cnt < 2000) begin
            if (req_ready) bad = 1'b1;
            tick();
            cnt++;
        end
        check_eq({tag, "_len"}, cnt, 256);
        check_eq({tag, "_ready_low"}, {31'b0, bad}, 0);
        check_eq({tag, "_ready_after"}, {31'b0, req_ready}, 1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [1:0] m, input logic [DATA_W-1:0] d);
        logic exp_err;
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_mode = m; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
        exp_err = (m == 2'b11) || (m == 2'b01 && d[1:0] == 2'b10);
        check_eq("wr_err", {31'b0, wr_err}, {31'b0, exp_err});
        case (m)
            2'b00: begin m_tag[a] = 2'b00; m_val[a] = d[0] ? 1 : 0; end
            2'b01: begin
                m_tag[a] = 2'b01;
                if (d[1:0] == 2'b01)      m_val[a] = 1;
                else if (d[1:0] == 2'b11) m_val[a] = -1;
                else                      m_val[a] = 0;
            end
            2'b10: begin m_tag[a] = 2'b10; m_val[a] = d; end
            default: ;
        endcase
    endtask

    task automatic rd(input logic [7:0] a, input logic [1:0] m);
        logic              ee;
        logic [DATA_W-1:0] ev;
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_mode = m; req_addr = a;
        ee = (m == 2'b11) || (m_tag[a] != m);
        ev = ee ? '0 : m_val[a];
        tick();
        req_valid = 1'b0;
        check_eq("rd_valid", {31'b0, resp_valid}, 1);
        check_eq("rd_data", resp_rdata, ev);
        check_eq("rd_err", {31'b0, resp_err}, {31'b0, ee});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_resp_valid"}, {31'b0, resp_valid}, 0);
        check_eq({tag, "_resp_rdata"}, resp_rdata, 0);
        check_eq({tag, "_resp_err"}, {31'b0, resp_err}, 0);
        check_eq({tag, "_wr_err"}, {31'b0, wr_err}, 0);
        check_eq({tag, "_busy"}, {31'b0, clear_busy}, 1);
        check_eq({tag, "_ready"}, {31'b0, req_ready}, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] held;
        model_clear();

        // Power-on reset and initial clear
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("por");
        rst_n = 1'b1;
        count_clear("por_clear");

        // Full-precision round trip, write then read in the next cycle
        wr(8'h10, 2'b10, 32'hDEADBEEF);
        rd(8'h10, 2'b10);
        check_eq("full_literal", resp_rdata, 32'hDEADBEEF);

        // Ternary encodings, including coerced 2'b10
        wr(8'h20, 2'b01, 32'h3);
        wr(8'h21, 2'b01, 32'h1);
        wr(8'h22, 2'b01, 32'h2);
        rd(8'h20, 2'b01);
        check_eq("tern_m1", resp_rdata, 32'hFFFFFFFF);
        rd(8'h21, 2'b01);
        rd(8'h22, 2'b01);
        check_eq("tern_coerced", resp_rdata, 32'h0);

        // Binary store and precision mismatch
        wr(8'h30, 2'b00, 32'h3);
        rd(8'h30, 2'b01);
        check_eq("mismatch_err", {31'b0, resp_err}, 1);
        rd(8'h30, 2'b00);
        check_eq("bin_literal", resp_rdata, 32'h1);

        // Illegal mode: write ignored, read errors
        wr(8'h10, 2'b11, 32'h12345678);
        rd(8'h10, 2'b10);
        rd(8'h10, 2'b11);
        rd(8'h55, 2'b10);

        // Back-pressure: response held stable, requests blocked
        tick();
        resp_ready = 1'b0;
        rd(8'h10, 2'b10);
        held = resp_rdata;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid", {31'b0, resp_valid}, 1);
            check_eq("bp_data", resp_rdata, held);
            check_eq("bp_ready", {31'b0, req_ready}, 0);
        end
        resp_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", {31'b0, req_ready}, 1);
        rd(8'h20, 2'b01);
        rd(8'h21, 2'b01);
        rd(8'h30, 2'b00);
        rd(8'h10, 2'b10);
        tick();
        check_eq("drained", {31'b0, resp_valid}, 0);

        // Randomized traffic over a small address window
        for (int i = 0; i < 400; i++) begin
            logic [7:0]        a;
            logic [1:0]        m;
            logic [DATA_W-1:0] d;
            a = 8'h40 + 8'($urandom_range(0, 15));
            m = 2'($urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 1) == 1) wr(a, m, d);
            else                           rd(a, m);
            if ($urandom_range(0, 3) == 0) begin
                tick();
                check_eq("idle_resp", {31'b0, resp_valid}, 0);
                check_eq("idle_wr_err", {31'b0, wr_err}, 0);
            end
        end

        // Clear on demand with a pending response that must survive it
        wr(8'h60, 2'b10, 32'hCAFEF00D);
        tick();
        resp_ready = 1'b0;
        rd(8'h60, 2'b10);
        held = resp_rdata;
        clear_req = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_mode = 2'b10; req_addr = 8'h61; req_wdata = 32'h1;
        #1;
        check_eq("clear_req_blocks", {31'b0, req_ready}, 0);
        tick();
        clear_req = 1'b0;
        req_valid = 1'b0;
        check_eq("clear_keeps_valid", {31'b0, resp_valid}, 1);
        check_eq("clear_keeps_data", resp_rdata, held);
        model_clear();
        resp_ready = 1'b1;
        count_clear("req_clear");
        rd(8'h60, 2'b10);
        rd(8'h61, 2'b10);
        rd(8'h20, 2'b01);

        // Reset 100 cycles into a clear restarts it from address 0
        wr(8'h70, 2'b00, 32'h1);
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (100) tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("mid_rst");
        rst_n = 1'b1;
        model_clear();
        count_clear("rst_clear");
        rd(8'h70, 2'b00);
        wr(8'h70, 2'b00, 32'h1);
        rd(8'h70, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
